// File: rtl/hdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hdma_ctrl
// Brief    : CGB VRAM DMA control block. Owns HDMA1..HDMA5 (FF51..FF55), runs
//            the general-purpose / HBlank mode state machine, launches the DMA
//            engine with a one-cycle DMA_start pulse and advances source and
//            destination block pointers on every GDMA_finished.
// Options  : `define HDMA_LCD_OFF_EN -> an HBlank transfer started while the
//            LCD is off launches its first block immediately.
// Revision : 1.0 - initial release
// ============================================================================
module hdma_ctrl #(
  parameter logic [15:0] REG_BASE = 16'hFF51
) (
  input  logic        clk4_2,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_rd_sel,
  output logic [7:0]  cpu_rd_data,
  input  logic        hblank_start,
  input  logic        lcd_on,
  input  logic        GDMA_finished,
  output logic [7:0]  HDMA1,
  output logic [7:0]  HDMA2,
  output logic [7:0]  HDMA3,
  output logic [7:0]  HDMA4,
  output logic [7:0]  HDMA5,
  output logic        DMA_start,
  output logic        dma_busy,
  output logic        hdma_active
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_GDMA_BUSY  = 2'd1;
  localparam logic [1:0] ST_HDMA_WAIT  = 2'd2;
  localparam logic [1:0] ST_HDMA_BLOCK = 2'd3;

  localparam logic [15:0] REG_LAST = REG_BASE + 16'd4;

  logic [1:0]  state_q, state_d;
  logic        launch_q, launch_d;
  logic [11:0] src_blk_q, src_blk_d;
  logic [8:0]  dst_blk_q, dst_blk_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  remaining_q, remaining_d;
  logic [7:0]  status_q, status_d;
  logic        term_pend_q, term_pend_d;

  logic [2:0]  w_idx;
  logic        w_wr_reg;
  logic        w_wr_ctl;
  logic        w_term_req;
  logic        w_lcd_off_launch;

  // Register offset within the block; the low three bits suffice because the
  // block spans only five addresses.
  assign cpu_rd_sel = (cpu_addr >= REG_BASE) && (cpu_addr <= REG_LAST);
  assign w_idx      = cpu_addr[2:0] - REG_BASE[2:0];
  assign w_wr_reg   = cpu_wr && cpu_rd_sel;
  assign w_wr_ctl   = w_wr_reg && (w_idx == 3'd4);
  assign w_term_req = w_wr_ctl && !cpu_wr_data[7];

`ifdef HDMA_LCD_OFF_EN
  assign w_lcd_off_launch = !lcd_on;
`else
  assign w_lcd_off_launch = 1'b0;
`endif

  // State register and registered launch pulse
  always_ff @(posedge clk4_2) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
    end
  end

  // Next-state logic; a launch is flagged on every transition into a transfer
  always_comb begin
    state_d  = state_q;
    launch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_wr_ctl) begin
          if (!cpu_wr_data[7]) begin
            state_d  = ST_GDMA_BUSY;
            launch_d = 1'b1;
          end else if (w_lcd_off_launch) begin
            state_d  = ST_HDMA_BLOCK;
            launch_d = 1'b1;
          end else begin
            state_d  = ST_HDMA_WAIT;
          end
        end
      end
      ST_GDMA_BUSY: begin
        if (GDMA_finished) state_d = ST_IDLE;
      end
      ST_HDMA_WAIT: begin
        // Termination takes priority over a coincident HBlank
        if (w_term_req) begin
          state_d = ST_IDLE;
        end else if (hblank_start && lcd_on) begin
          state_d  = ST_HDMA_BLOCK;
          launch_d = 1'b1;
        end
      end
      ST_HDMA_BLOCK: begin
        if (GDMA_finished) begin
          if ((remaining_q == 7'd0) || term_pend_q || w_term_req) state_d = ST_IDLE;
          else                                                    state_d = ST_HDMA_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: pointer writes, length capture and post-block updates
  always_comb begin
    src_blk_d   = src_blk_q;
    dst_blk_d   = dst_blk_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    status_d    = status_q;
    term_pend_d = term_pend_q;

    if ((state_q == ST_IDLE) && w_wr_reg) begin
      case (w_idx)
        3'd0:    src_blk_d[11:4] = cpu_wr_data;
        3'd1:    src_blk_d[3:0]  = cpu_wr_data[7:4];
        3'd2:    dst_blk_d[8:4]  = cpu_wr_data[4:0];
        3'd3:    dst_blk_d[3:0]  = cpu_wr_data[7:4];
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (w_wr_ctl) begin
          len_d = cpu_wr_data[6:0];
          if (cpu_wr_data[7]) begin
            remaining_d = cpu_wr_data[6:0];
            term_pend_d = 1'b0;
          end
        end
      end
      ST_GDMA_BUSY: begin
        if (GDMA_finished) begin
          src_blk_d = src_blk_q + {5'd0, len_q} + 12'd1;
          dst_blk_d = dst_blk_q + {2'd0, len_q} + 9'd1;
          status_d  = 8'hFF;
        end
      end
      ST_HDMA_WAIT: begin
        if (w_term_req) status_d = {1'b1, remaining_q};
      end
      ST_HDMA_BLOCK: begin
        if (w_term_req) term_pend_d = 1'b1;
        if (GDMA_finished) begin
          src_blk_d = src_blk_q + 12'd1;
          dst_blk_d = dst_blk_q + 9'd1;
          if (remaining_q == 7'd0) begin
            status_d = 8'hFF;
          end else begin
            remaining_d = remaining_q - 7'd1;
            if (term_pend_q || w_term_req) status_d = {1'b1, remaining_q - 7'd1};
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk4_2) begin
    if (reset) begin
      src_blk_q   <= 12'd0;
      dst_blk_q   <= 9'd0;
      len_q       <= 7'd0;
      remaining_q <= 7'd0;
      status_q    <= 8'hFF;
      term_pend_q <= 1'b0;
    end else begin
      src_blk_q   <= src_blk_d;
      dst_blk_q   <= dst_blk_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      status_q    <= status_d;
      term_pend_q <= term_pend_d;
    end
  end

  // Outputs decoded from state and datapath registers
  always_comb begin
    DMA_start   = launch_q;
    dma_busy    = (state_q == ST_GDMA_BUSY) || (state_q == ST_HDMA_BLOCK);
    hdma_active = (state_q == ST_HDMA_WAIT) || (state_q == ST_HDMA_BLOCK);
    HDMA1       = src_blk_q[11:4];
    HDMA2       = {src_blk_q[3:0], 4'h0};
    HDMA3       = {3'b000, dst_blk_q[8:4]};
    HDMA4       = {dst_blk_q[3:0], 4'h0};
    HDMA5       = (state_q == ST_GDMA_BUSY) ? {1'b0, len_q} : 8'h00;
    cpu_rd_data = 8'hFF;
    if (cpu_rd_sel && (w_idx == 3'd4)) begin
      cpu_rd_data = hdma_active ? {~hdma_active, remaining_q} : status_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdma_ctrl
// Brief    : Directed self-checking bench for hdma_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdma_ctrl;

  logic        clk4_2 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wr_data = 8'h00;
  logic        cpu_rd_sel;
  logic [7:0]  cpu_rd_data;
  logic        hblank_start = 1'b0;
  logic        lcd_on = 1'b1;
  logic        GDMA_finished = 1'b0;
  logic [7:0]  HDMA1, HDMA2, HDMA3, HDMA4, HDMA5;
  logic        DMA_start, dma_busy, hdma_active;

  int errors = 0;
  int checks = 0;
  int n_start = 0;

  hdma_ctrl #(.REG_BASE(16'hFF51)) dut (
    .clk4_2(clk4_2), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_sel(cpu_rd_sel), .cpu_rd_data(cpu_rd_data),
    .hblank_start(hblank_start), .lcd_on(lcd_on), .GDMA_finished(GDMA_finished),
    .HDMA1(HDMA1), .HDMA2(HDMA2), .HDMA3(HDMA3), .HDMA4(HDMA4), .HDMA5(HDMA5),
    .DMA_start(DMA_start), .dma_busy(dma_busy), .hdma_active(hdma_active)
  );

  always #5 clk4_2 = ~clk4_2;

  // Launch pulses counted mid-cycle
  always @(negedge clk4_2) if (DMA_start === 1'b1) n_start++;

  task automatic tick();
    @(posedge clk4_2);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wr_data = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rd_data;
  endtask

  task automatic pulse_hb();
    hblank_start = 1'b1; tick(); hblank_start = 1'b0;
  endtask

  task automatic pulse_fin();
    GDMA_finished = 1'b1; tick(); GDMA_finished = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    checks++;
    if ({DMA_start, dma_busy, hdma_active} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {DMA_start, dma_busy, hdma_active});
    end
    checks++;
    if ({HDMA1, HDMA2, HDMA3, HDMA4, HDMA5} !== 40'h0) begin
      errors++; $display("FAIL reset_regs: got %h want 0", {HDMA1, HDMA2, HDMA3, HDMA4, HDMA5});
    end
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'hFF || cpu_rd_sel !== 1'b1) begin
      errors++; $display("FAIL reset_ff55: got %h sel %b want ff sel 1", d, cpu_rd_sel);
    end
    rd(16'hFF51, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL rd_ff51: got %h want ff", d); end
    rd(16'hFF50, d);
    checks++;
    if (cpu_rd_sel !== 1'b0) begin errors++; $display("FAIL sel_ff50: got %b want 0", cpu_rd_sel); end
    rd(16'hFF56, d);
    checks++;
    if (cpu_rd_sel !== 1'b0) begin errors++; $display("FAIL sel_ff56: got %b want 0", cpu_rd_sel); end
  endtask

  task automatic test_gdma();
    logic [7:0] d;
    int s0;
    wr(16'hFF51, 8'hC1); wr(16'hFF52, 8'h2F); wr(16'hFF53, 8'hE3); wr(16'hFF54, 8'h45);
    s0 = n_start;
    checks++;
    if (DMA_start !== 1'b0) begin errors++; $display("FAIL gdma_prelaunch: got %b want 0", DMA_start); end
    wr(16'hFF55, 8'h03);
    checks++;
    if (DMA_start !== 1'b1 || dma_busy !== 1'b1) begin
      errors++; $display("FAIL gdma_launch: got start %b busy %b want 1 1", DMA_start, dma_busy);
    end
    checks++;
    if ({HDMA1, HDMA2, HDMA3, HDMA4, HDMA5} !== 40'hC120034003) begin
      errors++; $display("FAIL gdma_regs: got %h want c120034003", {HDMA1, HDMA2, HDMA3, HDMA4, HDMA5});
    end
    wr(16'hFF51, 8'h00);
    checks++;
    if (DMA_start !== 1'b0 || dma_busy !== 1'b1 || HDMA1 !== 8'hC1 || HDMA5 !== 8'h03) begin
      errors++; $display("FAIL gdma_hold: got start %b busy %b h1 %h h5 %h want 0 1 c1 03",
                         DMA_start, dma_busy, HDMA1, HDMA5);
    end
    tick(); tick();
    pulse_fin();
    checks++;
    if (dma_busy !== 1'b0 || {HDMA1, HDMA2, HDMA3, HDMA4, HDMA5} !== 40'hC160038000) begin
      errors++; $display("FAIL gdma_done: got busy %b regs %h want 0 c160038000",
                         dma_busy, {HDMA1, HDMA2, HDMA3, HDMA4, HDMA5});
    end
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL gdma_status: got %h want ff", d); end
    checks++;
    if (n_start - s0 != 1) begin errors++; $display("FAIL gdma_pulses: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_hblank();
    logic [7:0] d;
    int s0;
    lcd_on = 1'b1;
    pulse_hb();
    s0 = n_start;
    wr(16'hFF55, 8'h81);
    rd(16'hFF55, d);
    checks++;
    if (DMA_start !== 1'b0 || hdma_active !== 1'b1 || dma_busy !== 1'b0 || d !== 8'h01) begin
      errors++; $display("FAIL hb_wait: got start %b act %b busy %b rd %h want 0 1 0 01",
                         DMA_start, hdma_active, dma_busy, d);
    end
    tick(); tick(); tick();
    checks++;
    if (n_start != s0) begin errors++; $display("FAIL hb_nolaunch: got %0d want 0", n_start - s0); end
    pulse_hb();
    checks++;
    if (DMA_start !== 1'b1 || dma_busy !== 1'b1 || HDMA5 !== 8'h00) begin
      errors++; $display("FAIL hb_launch1: got start %b busy %b h5 %h want 1 1 00", DMA_start, dma_busy, HDMA5);
    end
    tick();
    pulse_fin();
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'h00 || hdma_active !== 1'b1 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL hb_block1: got rd %h act %b busy %b want 00 1 0", d, hdma_active, dma_busy);
    end
    lcd_on = 1'b0;
    pulse_hb();
    checks++;
    if (DMA_start !== 1'b0) begin errors++; $display("FAIL hb_lcdoff: got %b want 0", DMA_start); end
    lcd_on = 1'b1;
    pulse_hb();
    tick();
    pulse_fin();
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'hFF || hdma_active !== 1'b0) begin
      errors++; $display("FAIL hb_done: got rd %h act %b want ff 0", d, hdma_active);
    end
    checks++;
    if ({HDMA1, HDMA2, HDMA3, HDMA4} !== 32'hC18003A0) begin
      errors++; $display("FAIL hb_ptrs: got %h want c18003a0", {HDMA1, HDMA2, HDMA3, HDMA4});
    end
    checks++;
    if (n_start - s0 != 2) begin errors++; $display("FAIL hb_pulses: got %0d want 2", n_start - s0); end
  endtask

  task automatic test_terminate_wait();
    logic [7:0] d;
    int s0;
    lcd_on = 1'b1;
    s0 = n_start;
    wr(16'hFF55, 8'h85);
    for (int i = 0; i < 2; i++) begin
      pulse_hb(); tick(); pulse_fin();
    end
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL tw_remaining: got %h want 03", d); end
    wr(16'hFF55, 8'h00);
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'h83 || hdma_active !== 1'b0) begin
      errors++; $display("FAIL tw_status: got rd %h act %b want 83 0", d, hdma_active);
    end
    pulse_hb(); tick();
    checks++;
    if (n_start - s0 != 2) begin errors++; $display("FAIL tw_pulses: got %0d want 2", n_start - s0); end
    // Terminate write coinciding with HBlank: terminate wins
    wr(16'hFF55, 8'h82);
    s0 = n_start;
    cpu_addr = 16'hFF55; cpu_wr_data = 8'h00; cpu_wr = 1'b1; hblank_start = 1'b1;
    tick();
    cpu_wr = 1'b0; hblank_start = 1'b0;
    rd(16'hFF55, d);
    checks++;
    if (DMA_start !== 1'b0 || hdma_active !== 1'b0 || d !== 8'h82) begin
      errors++; $display("FAIL tw_race: got start %b act %b rd %h want 0 0 82", DMA_start, hdma_active, d);
    end
  endtask

  task automatic test_terminate_block();
    logic [7:0] d;
    int s0;
    lcd_on = 1'b1;
    s0 = n_start;
    wr(16'hFF55, 8'h84);
    pulse_hb();
    wr(16'hFF55, 8'h00);
    checks++;
    if (dma_busy !== 1'b1 || hdma_active !== 1'b1) begin
      errors++; $display("FAIL tb_pending: got busy %b act %b want 1 1", dma_busy, hdma_active);
    end
    pulse_fin();
    rd(16'hFF55, d);
    checks++;
    if (d !== 8'h83 || hdma_active !== 1'b0 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL tb_status: got rd %h act %b busy %b want 83 0 0", d, hdma_active, dma_busy);
    end
    pulse_hb(); tick();
    checks++;
    if (n_start - s0 != 1) begin errors++; $display("FAIL tb_pulses: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_wrap();
    lcd_on = 1'b1;
    wr(16'hFF51, 8'hFF); wr(16'hFF52, 8'hF0); wr(16'hFF53, 8'h9F); wr(16'hFF54, 8'hF0);
    wr(16'hFF55, 8'h81);
    checks++;
    if ({HDMA1, HDMA2, HDMA3, HDMA4} !== 32'hFFF01FF0) begin
      errors++; $display("FAIL wrap_pre: got %h want fff01ff0", {HDMA1, HDMA2, HDMA3, HDMA4});
    end
    pulse_hb(); tick(); pulse_fin();
    checks++;
    if ({HDMA1, HDMA2, HDMA3, HDMA4} !== 32'h00000000) begin
      errors++; $display("FAIL wrap_blk2: got %h want 00000000", {HDMA1, HDMA2, HDMA3, HDMA4});
    end
    pulse_hb(); tick(); pulse_fin();
    checks++;
    if ({HDMA1, HDMA2, HDMA3, HDMA4} !== 32'h00100010 || hdma_active !== 1'b0) begin
      errors++; $display("FAIL wrap_done: got %h act %b want 00100010 0", {HDMA1, HDMA2, HDMA3, HDMA4}, hdma_active);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int s0;
    wr(16'hFF51, 8'h12); wr(16'hFF53, 8'h05);
    s0 = n_start;
    wr(16'hFF55, 8'h10);
    tick();
    reset = 1'b1;
    tick();
    rd(16'hFF55, d);
    checks++;
    if ({DMA_start, dma_busy, hdma_active} !== 3'b000 || {HDMA1, HDMA2, HDMA3, HDMA4, HDMA5} !== 40'h0 || d !== 8'hFF) begin
      errors++; $display("FAIL rstmid_outs: got ctl %b regs %h rd %h want 000 0 ff",
                         {DMA_start, dma_busy, hdma_active}, {HDMA1, HDMA2, HDMA3, HDMA4, HDMA5}, d);
    end
    reset = 1'b0;
    tick(); tick();
    pulse_fin();
    tick();
    checks++;
    if (n_start - s0 != 1 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet: got pulses %0d busy %b want 1 0", n_start - s0, dma_busy);
    end
  endtask

  initial begin
    test_reset();
    test_gdma();
    test_hblank();
    test_terminate_wait();
    test_terminate_block();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
